// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-memory requesters, the arbiter and the single-port dmem.
// Carries both request ports, the shared read data return and the dmem we/a/d/q wires.
interface dmem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds it
    // until ackN (a one-cycle pulse); rdata is valid only while ack0|ack1 is high.
    // reqN must be low again by the IDLE cycle after ackN, otherwise it counts as a new request.
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;
    logic          busy;
    logic [1:0]    dbg_state;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        output ack0, ack1, rdata, mem_we, mem_a, mem_d, busy, dbg_state
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        input  ack0, ack1, rdata, mem_we, mem_a, mem_d, busy, dbg_state
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 64x32 data memory: each access runs
// IDLE -> ACCESS -> DONE, with round-robin or fixed priority between core and aux master.
module dmem_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          grant;
    logic          pick;
    logic          win;
    logic          last_gnt;
    logic          lat_we;
    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;
    logic [DW-1:0] rdata_q;

    // Requests are only looked at in IDLE; a tie goes to the port that did not win last.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        pick       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant      = 1'b1;
                    state_next = S_ACCESS;
                    if (bus.req0 && bus.req1)
                        pick = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
                    else
                        pick = bus.req1;
                end
            end
            S_ACCESS: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // a_q/d_q double as the memory address/data drivers, so they hold between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            win      <= 1'b0;
            last_gnt <= 1'b1;
            lat_we   <= 1'b0;
            a_q      <= '0;
            d_q      <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                win    <= pick;
                lat_we <= pick ? bus.we1    : bus.we0;
                a_q    <= pick ? bus.addr1  : bus.addr0;
                d_q    <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (state == S_ACCESS) begin
                rdata_q  <= lat_we ? '0 : bus.mem_q;
                last_gnt <= win;
            end
        end
    end

    // Write strobe exists only in ACCESS, so an async reset there cancels the write.
    assign bus.mem_we    = (state == S_ACCESS) && lat_we;
    assign bus.mem_a     = a_q;
    assign bus.mem_d     = d_q;
    assign bus.rdata     = rdata_q;
    assign bus.ack0      = (state == S_DONE) && !win;
    assign bus.ack1      = (state == S_DONE) && win;
    assign bus.busy      = (state != S_IDLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances, each with its own dmem model.
// Table of single transactions, corner-case sequences, and an ack-ordered expected queue.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(6), .DW(32)) b0 ();
    dmem_arbiter_if #(.AW(6), .DW(32)) b1 ();

    dmem_arbiter #(.AW(6), .DW(32), .FIXED_PRI(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    dmem_arbiter #(.AW(6), .DW(32), .FIXED_PRI(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // dmem models: async read, write on rising edge, power-up value all ones
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] ref_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'hFFFFFFFF;
            mem1[i] = 32'hFFFFFFFF;
            ref_mem[i] = 32'hFFFFFFFF;
        end
    end
    always @(posedge clk) if (b0.mem_we) mem0[b0.mem_a] <= b0.mem_d;
    always @(posedge clk) if (b1.mem_we) mem1[b1.mem_a] <= b1.mem_d;
    assign b0.mem_q = mem0[b0.mem_a];
    assign b1.mem_q = mem1[b1.mem_a];

    int tests = 0;
    int fails = 0;
    int we_cnt0 = 0;
    logic last_port0 = 1'b1;
    logic last_port1 = 1'b1;
    logic [32:0] exp_q [$];
    logic [32:0] exp1_q [$];
    logic [32:0] e0, e1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // scoreboard: each ack pops one {port, rdata} entry
    always @(negedge clk) begin
        if (b0.mem_we) we_cnt0++;
        if (!rst && (b0.ack0 || b0.ack1)) begin
            tests++;
            if (b0.ack0 && b0.ack1) begin
                fails++;
                $display("FAIL ack_overlap0: ack0=%b ack1=%b required one-hot", b0.ack0, b0.ack1);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb0_unexpected: ack port %0d rdata %h with nothing expected", b0.ack1, b0.rdata);
            end else begin
                e0 = exp_q.pop_front();
                if ({b0.ack1, b0.rdata} !== e0) begin
                    fails++;
                    $display("FAIL sb0_ack: got port %0d rdata %h expected port %0d rdata %h",
                             b0.ack1, b0.rdata, e0[32], e0[31:0]);
                end
            end
        end
        if (!rst && (b1.ack0 || b1.ack1)) begin
            tests++;
            if (b1.ack0 && b1.ack1) begin
                fails++;
                $display("FAIL ack_overlap1: ack0=%b ack1=%b required one-hot", b1.ack0, b1.ack1);
            end
            tests++;
            if (exp1_q.size() == 0) begin
                fails++;
                $display("FAIL sb1_unexpected: ack port %0d rdata %h with nothing expected", b1.ack1, b1.rdata);
            end else begin
                e1 = exp1_q.pop_front();
                if ({b1.ack1, b1.rdata} !== e1) begin
                    fails++;
                    $display("FAIL sb1_ack: got port %0d rdata %h expected port %0d rdata %h",
                             b1.ack1, b1.rdata, e1[32], e1[31:0]);
                end
            end
        end
    end

    // single transaction on the round-robin instance; request fields are scrambled after sampling
    task automatic do_txn(input logic port, input logic we, input logic [5:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int n;
        exp_q.push_back({port, exp});
        we_cnt0 = 0;
        if (port) begin
            b0.req1 = 1'b1; b0.we1 = we; b0.addr1 = addr; b0.wdata1 = wdata;
        end else begin
            b0.req0 = 1'b1; b0.we0 = we; b0.addr0 = addr; b0.wdata0 = wdata;
        end
        n = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) begin
                if (port) begin
                    b0.we1 = ~we; b0.addr1 = ~addr; b0.wdata1 = $urandom;
                end else begin
                    b0.we0 = ~we; b0.addr0 = ~addr; b0.wdata0 = $urandom;
                end
            end
            if (port ? b0.ack1 : b0.ack0) begin
                n = t;
                break;
            end
        end
        if (port) b0.req1 = 1'b0; else b0.req0 = 1'b0;
        chk("txn_latency", 64'(n), 64'd2);
        tick();
        chk("txn_we_cycles", 64'(we_cnt0), we ? 64'd1 : 64'd0);
        if (we) ref_mem[addr] = wdata;
        last_port0 = port;
    endtask

    // both ports hold req for n0/n1 transactions; expected grant order from the arbitration rule
    task automatic dual(input bit sel,
                        input logic we0, input logic [5:0] a0, input logic [31:0] d0, input logic [31:0] x0,
                        input logic we1, input logic [5:0] a1, input logic [31:0] d1, input logic [31:0] x1,
                        input int n0, input int n1);
        int r0, r1, done_t, total;
        logic lp;
        r0 = n0; r1 = n1;
        lp = sel ? last_port1 : last_port0;
        while (r0 > 0 || r1 > 0) begin
            logic p;
            if (r0 > 0 && r1 > 0) p = sel ? 1'b0 : ~lp;
            else p = (r1 > 0);
            if (sel) exp1_q.push_back({p, p ? x1 : x0});
            else exp_q.push_back({p, p ? x1 : x0});
            lp = p;
            if (p) r1--; else r0--;
        end
        if (sel) last_port1 = lp; else last_port0 = lp;
        if (sel) begin
            b1.we0 = we0; b1.addr0 = a0; b1.wdata0 = d0; b1.req0 = (n0 > 0);
            b1.we1 = we1; b1.addr1 = a1; b1.wdata1 = d1; b1.req1 = (n1 > 0);
        end else begin
            b0.we0 = we0; b0.addr0 = a0; b0.wdata0 = d0; b0.req0 = (n0 > 0);
            b0.we1 = we1; b0.addr1 = a1; b0.wdata1 = d1; b0.req1 = (n1 > 0);
        end
        r0 = n0; r1 = n1; total = n0 + n1; done_t = -1;
        for (int t = 1; t <= 3 * total + 6; t++) begin
            tick();
            if (sel ? b1.ack0 : b0.ack0) begin
                r0--;
                if (r0 == 0) begin if (sel) b1.req0 = 1'b0; else b0.req0 = 1'b0; end
            end
            if (sel ? b1.ack1 : b0.ack1) begin
                r1--;
                if (r1 == 0) begin if (sel) b1.req1 = 1'b0; else b0.req1 = 1'b0; end
            end
            if (r0 <= 0 && r1 <= 0) begin
                done_t = t;
                break;
            end
        end
        if (sel) begin b1.req0 = 1'b0; b1.req1 = 1'b0; end
        else begin b0.req0 = 1'b0; b0.req1 = 1'b0; end
        chk("dual_span", 64'(done_t), 64'(3 * total - 1));
        tick();
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    initial begin
        vt[0] = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b0, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b0, 6'd63, 32'h0,        32'hFFFFFFFF};
        vt[3] = '{1'b1, 1'b1, 6'd63, 32'h12345678, 32'h0};
        vt[4] = '{1'b0, 1'b0, 6'd63, 32'h0,        32'h12345678};
        vt[5] = '{1'b1, 1'b1, 6'd0,  32'hA5A5A5A5, 32'h0};
        vt[6] = '{1'b0, 1'b0, 6'd0,  32'h0,        32'hA5A5A5A5};
        vt[7] = '{1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF};

        b0.req0 = 0; b0.we0 = 0; b0.addr0 = 0; b0.wdata0 = 0;
        b0.req1 = 0; b0.we1 = 0; b0.addr1 = 0; b0.wdata1 = 0;
        b1.req0 = 0; b1.we0 = 0; b1.addr0 = 0; b1.wdata0 = 0;
        b1.req1 = 0; b1.we1 = 0; b1.addr1 = 0; b1.wdata1 = 0;

        rst = 1'b1;
        tick(); tick();
        chk("rst_ctrl", {b0.ack0, b0.ack1, b0.mem_we, b0.busy, b0.dbg_state, b0.mem_a}, 64'h0);
        chk("rst_mem_d", b0.mem_d, 64'h0);
        chk("rst_rdata", b0.rdata, 64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);

        // reset lands in ACCESS of a write: everything clears, no ack, word untouched
        b0.req0 = 1'b1; b0.we0 = 1'b1; b0.addr0 = 6'd7; b0.wdata0 = 32'h0BADF00D;
        tick();
        chk("abort_in_access", b0.dbg_state, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {b0.ack0, b0.ack1, b0.mem_we, b0.busy, b0.dbg_state, b0.mem_a}, 64'h0);
        chk("abort_mem_d", b0.mem_d, 64'h0);
        chk("abort_rdata", b0.rdata, 64'h0);
        b0.req0 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        last_port0 = 1'b1;
        last_port1 = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        chk("abort_no_write", mem0[7], 64'hFFFFFFFF);

        // simultaneous writes to one word right after reset: port 0 first, port 1 overwrites
        dual(1'b0, 1'b1, 6'd10, 32'h11111111, 32'h0, 1'b1, 6'd10, 32'h22222222, 32'h0, 1, 1);
        ref_mem[10] = 32'h22222222;
        do_txn(1'b0, 1'b0, 6'd10, 32'h0, 32'h22222222);

        for (int i = 0; i < 10; i++) begin
            logic p, w;
            logic [5:0] a;
            logic [31:0] d;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            do_txn(p, w, a, d, w ? 32'h0 : ref_mem[a]);
        end

        // continuous contention: strict alternation, 6 acks in 18 cycles
        dual(1'b0, 1'b0, 6'd5, 32'h0, ref_mem[5], 1'b0, 6'd63, 32'h0, ref_mem[63], 3, 3);
        dual(1'b0, 1'b0, 6'd0, 32'h0, ref_mem[0], 1'b0, 6'd10, 32'h0, ref_mem[10], 3, 1);
        // fixed priority: port 1 only after port 0 lets go
        dual(1'b1, 1'b0, 6'd1, 32'h0, 32'hFFFFFFFF, 1'b1, 6'd2, 32'h33333333, 32'h0, 3, 1);
        chk("fixed_write", mem1[2], 64'h33333333);

        for (int t = 0; t < 5; t++) tick();
        chk("sb0_drained", 64'(exp_q.size()), 64'd0);
        chk("sb1_drained", 64'(exp1_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
